// File: rtl/trigger_wheel_gen.sv
// trigger_wheel_gen: synthetic N-M missing-tooth crank wheel generator.
// Define TRIG_WHEEL_RAMP_EN to ramp the tooth period by ramp_step per slot.
module trigger_wheel_gen #(
    parameter int PERIOD_W = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CNT_W-1:0]    tooth_cnt,
    input  logic [CNT_W-1:0]    teeth_missing,
    input  logic [PERIOD_W-1:0] tooth_period,
    input  logic [15:0]         ramp_step,
    output logic                vr_out,
    output logic [CNT_W-1:0]    tooth_idx,
    output logic                rev_start,
    output logic                running,
    output logic                cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0]    r_idx;
    logic [CNT_W-1:0]    w_idx_nx;
    logic                r_rev;
    logic                w_rev_nx;
    logic                r_err;
    logic                w_err_nx;
    logic [CNT_W-1:0]    r_lcnt;
    logic [CNT_W-1:0]    r_lmiss;
    logic [PERIOD_W-1:0] r_lper;
    logic [PERIOD_W-1:0] w_lper_ramp;
    logic                w_latch;
    logic                w_step;
    logic                w_wrap;

    // Validity is judged on the values about to be latched.
    logic [CNT_W:0]      w_miss2;
    logic                w_in_ok;
    assign w_miss2 = {1'b0, teeth_missing} + (CNT_W+1)'(2);
    assign w_in_ok = (tooth_cnt >= CNT_W'(3))
                  && (w_miss2 <= {1'b0, tooth_cnt})
                  && (tooth_period >= PERIOD_W'(4));

    logic [PERIOD_W-1:0] w_half;
    logic                w_slot_end;
    logic [CNT_W-1:0]    w_idx_inc;
    logic [CNT_W-1:0]    w_gap_idx;
    assign w_half     = r_lper >> 1;
    assign w_slot_end = (r_cnt == r_lper - PERIOD_W'(1));
    assign w_idx_inc  = r_idx + CNT_W'(1);
    assign w_gap_idx  = r_lcnt - r_lmiss;

`ifdef TRIG_WHEEL_RAMP_EN
    logic signed [PERIOD_W+1:0] w_sum;
    assign w_sum = $signed({2'b00, r_lper})
                 + $signed({{(PERIOD_W+2-16){ramp_step[15]}}, ramp_step});
    always_comb begin
        w_lper_ramp = w_sum[PERIOD_W-1:0];
        if (w_sum[PERIOD_W+1] || (w_sum[PERIOD_W:0] < (PERIOD_W+1)'(4)))
            w_lper_ramp = PERIOD_W'(4);
        else if (w_sum[PERIOD_W])
            w_lper_ramp = '1;
    end
`else
    logic w_unused;
    assign w_unused    = ^ramp_step ^ w_step;
    assign w_lper_ramp = r_lper;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + PERIOD_W'(1);
        w_idx_nx   = r_idx;
        w_rev_nx   = 1'b0;
        w_err_nx   = r_err;
        w_latch    = 1'b0;
        w_step     = 1'b0;
        w_wrap     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                w_idx_nx = '0;
                if (enable) begin
                    w_latch = 1'b1;
                    if (w_in_ok) begin
                        w_state_nx = S_HI;
                        w_rev_nx   = 1'b1;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (r_cnt == w_half - PERIOD_W'(1))
                    w_state_nx = S_LO;
            end
            S_LO: begin
                if (w_slot_end) begin
                    w_cnt_nx = '0;
                    w_step   = 1'b1;
                    if (w_idx_inc != w_gap_idx) begin
                        w_state_nx = S_HI;
                        w_idx_nx   = w_idx_inc;
                    end else if (r_lmiss == '0) begin
                        w_wrap = 1'b1;
                    end else begin
                        w_state_nx = S_GAP;
                        w_idx_nx   = w_idx_inc;
                    end
                end
            end
            S_GAP: begin
                if (w_slot_end) begin
                    w_cnt_nx = '0;
                    w_step   = 1'b1;
                    if (r_idx == r_lcnt - CNT_W'(1))
                        w_wrap = 1'b1;
                    else
                        w_idx_nx = w_idx_inc;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        // Disable wins over validity at the wrap point.
        if (w_wrap) begin
            w_idx_nx = '0;
            if (!enable) begin
                w_state_nx = S_IDLE;
            end else begin
                w_latch = 1'b1;
                if (w_in_ok) begin
                    w_state_nx = S_HI;
                    w_rev_nx   = 1'b1;
                end else begin
                    w_state_nx = S_IDLE;
                    w_err_nx   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rev   <= 1'b0;
            r_err   <= 1'b0;
            r_lcnt  <= '0;
            r_lmiss <= '0;
            r_lper  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_rev   <= w_rev_nx;
            r_err   <= w_err_nx;
            if (w_latch) begin
                r_lcnt  <= tooth_cnt;
                r_lmiss <= teeth_missing;
                r_lper  <= tooth_period;
            end else if (w_step) begin
                r_lper  <= w_lper_ramp;
            end
        end
    end

    assign vr_out    = (r_state == S_HI);
    assign running   = (r_state != S_IDLE);
    assign tooth_idx = r_idx;
    assign rev_start = r_rev;
    assign cfg_err   = r_err;

endmodule

// File: tb/tb_trigger_wheel_gen.sv
// Self-checking bench for trigger_wheel_gen: config table plus
// directed tooth-stream sequences.
module tb_trigger_wheel_gen;
    localparam int PW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] tooth_cnt = '0;
    logic [CW-1:0] teeth_missing = '0;
    logic [PW-1:0] tooth_period = '0;
    logic [15:0]   ramp_step = '0;
    logic          vr_out;
    logic [CW-1:0] tooth_idx;
    logic          rev_start;
    logic          running;
    logic          cfg_err;

    int errors = 0;
    int checks = 0;
    int ns = 0;
    int last_rise = 0;
    logic s_cur = 1'b0;
    logic s_prev = 1'b0;

    typedef struct {
        int cnt;
        int miss;
        int per;
        int exp_err;
        int exp_run;
    } vec_t;
    vec_t vecs[8];

    trigger_wheel_gen #(.PERIOD_W(PW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .tooth_cnt     (tooth_cnt),
        .teeth_missing (teeth_missing),
        .tooth_period  (tooth_period),
        .ramp_step     (ramp_step),
        .vr_out        (vr_out),
        .tooth_idx     (tooth_idx),
        .rev_start     (rev_start),
        .running       (running),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        ns++;
        s_prev = s_cur;
        s_cur  = vr_out;
    endtask

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rise_gap(input int limit, output int gap);
        bit found;
        found = 1'b0;
        gap   = -1;
        for (int i = 0; i < limit && !found; i++) begin
            tick();
            if (s_cur && !s_prev) found = 1'b1;
        end
        if (found) begin
            gap       = ns - last_rise;
            last_rise = ns;
        end
    endtask

    task automatic to_fall(input int limit, output int n);
        n = 0;
        while (s_cur && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        ramp_step = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic cfg(input int c, input int m, input int p);
        tooth_cnt     = CW'(c);
        teeth_missing = CW'(m);
        tooth_period  = PW'(p);
    endtask

    task automatic start();
        int g;
        last_rise = ns;
        enable    = 1'b1;
        rise_gap(5, g);
        chk("start latency", g, 1);
        chk("start rev_start", rev_start, 1);
        chk("start idx", tooth_idx, 0);
    endtask

    initial begin
        int g;
        int n;
        int rev_pos;

        vecs[0] = '{60, 2, 100, 0, 1};
        vecs[1] = '{60, 59, 100, 1, 0};
        vecs[2] = '{60, 58, 100, 0, 1};
        vecs[3] = '{3, 1, 4, 0, 1};
        vecs[4] = '{2, 0, 4, 1, 0};
        vecs[5] = '{3, 0, 3, 1, 0};
        vecs[6] = '{4, 0, 5, 0, 1};
        vecs[7] = '{3, 2, 4, 1, 0};

        reset_n = 1'b0;
        tick();
        chk("reset vr_out", vr_out, 0);
        chk("reset idx", tooth_idx, 0);
        chk("reset rev_start", rev_start, 0);
        chk("reset running", running, 0);
        chk("reset cfg_err", cfg_err, 0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            cfg(vecs[v].cnt, vecs[v].miss, vecs[v].per);
            enable = 1'b1;
            tick();
            tick();
            tick();
            chk("vec cfg_err", cfg_err, vecs[v].exp_err);
            chk("vec running", running, vecs[v].exp_run);
            if (vecs[v].exp_err != 0) chk("vec vr_out", vr_out, 0);
        end

        // 60-2 wheel, 100 clocks per slot
        do_reset();
        cfg(60, 2, 100);
        start();
        rev_pos = last_rise;
        to_fall(200, n);
        chk("t1 high time", n, 50);
        for (int k = 1; k < 58; k++) begin
            rise_gap(150, g);
            chk("t1 spacing", g, 100);
            chk("t1 idx", tooth_idx, k);
            chk("t1 rev_start low", rev_start, 0);
        end
        rise_gap(400, g);
        chk("t1 gap spacing", g, 300);
        chk("t1 wrap idx", tooth_idx, 0);
        chk("t1 wrap rev_start", rev_start, 1);
        chk("t1 rev period", last_rise - rev_pos, 6000);
        chk("t1 running", running, 1);

        // 4-0 wheel, no gap
        do_reset();
        cfg(4, 0, 5);
        start();
        to_fall(20, n);
        chk("t2 high time", n, 2);
        for (int k = 1; k <= 4; k++) begin
            rise_gap(20, g);
            chk("t2 spacing", g, 5);
            chk("t2 idx", tooth_idx, k % 4);
            chk("t2 rev_start", rev_start, (k == 4) ? 1 : 0);
        end

        // mid-rev period change, enable glitch before wrap
        do_reset();
        cfg(60, 2, 100);
        start();
        for (int k = 1; k < 58; k++) begin
            if (k == 11) tooth_period = PW'(200);
            if (k == 20) enable = 1'b0;
            if (k == 30) enable = 1'b1;
            rise_gap(250, g);
            chk("t3 spacing", g, 100);
        end
        rise_gap(700, g);
        chk("t3 gap spacing", g, 300);
        chk("t3 wrap rev_start", rev_start, 1);
        to_fall(300, n);
        chk("t3 new high time", n, 100);
        rise_gap(400, g);
        chk("t3 new spacing", g, 200);
        chk("t3 new idx", tooth_idx, 1);

        // enable dropped at idx 20
        do_reset();
        cfg(60, 2, 100);
        start();
        for (int k = 1; k < 58; k++) begin
            if (k == 21) enable = 1'b0;
            rise_gap(150, g);
            chk("t4 spacing", g, 100);
        end
        for (int i = 0; i < 250; i++) tick();
        chk("t4 in gap running", running, 1);
        chk("t4 in gap vr_out", vr_out, 0);
        for (int i = 0; i < 60; i++) tick();
        chk("t4 stop running", running, 0);
        chk("t4 stop idx", tooth_idx, 0);
        chk("t4 stop rev_start", rev_start, 0);
        rise_gap(500, g);
        chk("t4 no more teeth", g, -1);
        chk("t4 cfg_err", cfg_err, 0);

        // invalid config sticks until reset
        do_reset();
        cfg(60, 59, 100);
        enable = 1'b1;
        tick();
        tick();
        chk("t5 cfg_err", cfg_err, 1);
        chk("t5 vr_out", vr_out, 0);
        enable = 1'b0;
        tick();
        chk("t5 sticky", cfg_err, 1);
        do_reset();
        chk("t5 cleared", cfg_err, 0);

        // invalid config at slot-0 entry
        do_reset();
        cfg(4, 0, 5);
        start();
        teeth_missing = CW'(3);
        for (int i = 0; i < 25; i++) tick();
        chk("t5b running", running, 0);
        chk("t5b cfg_err", cfg_err, 1);
        chk("t5b vr_out", vr_out, 0);

        // disable has priority over invalid config at wrap
        do_reset();
        cfg(4, 0, 5);
        start();
        teeth_missing = CW'(3);
        enable = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        chk("t5c running", running, 0);
        chk("t5c cfg_err", cfg_err, 0);

        // async reset in the middle of a high phase
        do_reset();
        cfg(60, 2, 100);
        start();
        rise_gap(150, g);
        tick();
        tick();
        chk("t6 pre vr_out", vr_out, 1);
        chk("t6 pre idx", tooth_idx, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 vr_out", vr_out, 0);
        chk("t6 running", running, 0);
        chk("t6 idx", tooth_idx, 0);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

`ifdef TRIG_WHEEL_RAMP_EN
        do_reset();
        cfg(60, 0, 100);
        ramp_step = 16'hFFFF;
        start();
        for (int k = 0; k < 5; k++) begin
            rise_gap(200, g);
            chk("ramp spacing", g, 100 - k);
        end
        do_reset();
        cfg(60, 0, 8);
        ramp_step = 16'hFFFF;
        start();
        for (int k = 0; k < 7; k++) begin
            rise_gap(20, g);
            chk("ramp clamp", g, (8 - k < 4) ? 4 : 8 - k);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_wheel_gen.md
Name: trigger_wheel_gen

Overview:
- Synthetic crank-wheel generator producing a digital VR-style tooth stream (N-M missing-tooth pattern).
- Acts as the encoder counterpart of the tooth-sync decoder.
- Drives the sync path in bench/HIL builds (muxed onto vrin) so ignition and injection can be exercised without an engine.
- Config is taken from the SPI register file and applied only at revolution boundaries.

Parameters:
- PERIOD_W, 32, width of tooth period counter and tooth_period input (clock cycles).
- CNT_W, 16, width of tooth count, missing count and tooth index.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run request, level
- tooth_cnt  in  CNT_W  total tooth slots per rev, including missing ones (e.g. 60)
- teeth_missing  in  CNT_W  missing slots at end of rev (e.g. 2)
- tooth_period  in  PERIOD_W  clocks per tooth slot
- ramp_step  in  16  signed per-tooth period delta (only with TRIG_WHEEL_RAMP_EN)
- vr_out  out  1  generated tooth signal; rising edge = tooth
- tooth_idx  out  CNT_W  current slot index, 0 = first tooth after gap
- rev_start  out  1  one-cycle pulse at the rising edge of slot 0
- running  out  1  high while generating
- cfg_err  out  1  sticky, set when a latch attempt sees invalid config

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: vr_out=0, tooth_idx=0, rev_start=0, running=0, cfg_err=0.
  - Internals: state=IDLE, all counters 0.
- Config latch:
  - Sample points: on leaving IDLE and at every slot-0 entry, latch tooth_cnt, teeth_missing and tooth_period into shadow regs (L_cnt, L_miss, L_per).
  - Inputs are ignored mid-revolution.
- Validity: L_cnt>=3, L_miss<=L_cnt-2, L_per>=4.
  - Invalid in IDLE: stay IDLE, set cfg_err.
  - Invalid at slot-0 entry: go IDLE with vr_out=0, running=0, set cfg_err.
  - cfg_err clears only on reset.
- States:
  - IDLE:
    - vr_out=0, running=0.
    - If enable and config valid: latch, then on the next cycle enter HI with tooth_idx=0 and pulse rev_start.
  - HI:
    - vr_out=1.
    - Lasts L_per>>1 cycles, counted from entry; then go to LO.
  - LO:
    - vr_out=0 for the remaining L_per-(L_per>>1) cycles.
    - At slot end, tooth_idx increments. If the new idx is L_cnt-L_miss, go to GAP, else go to HI.
  - GAP:
    - vr_out=0 for L_miss*L_per cycles, counted as L_miss whole slots; tooth_idx steps each slot.
    - At the end of the final slot, wrap: tooth_idx=0, latch config, rev_start pulses, go to HI.
  - L_miss=0: GAP is skipped. LO of slot L_cnt-1 wraps directly to slot 0.
- Slot length: exactly L_per cycles. Rising-edge spacing is L_per cycles, or (L_miss+1)*L_per across the gap.
- enable deassert:
  - The current revolution completes.
  - At the wrap point, go IDLE instead of HI; vr_out stays 0.
  - enable reasserted before the wrap continues seamlessly.
- Simultaneous events: wrap, latch and enable check are evaluated in the same cycle. The enable check takes priority over validity: disabled means IDLE with no cfg_err.
- Arithmetic:
  - Slot counter is PERIOD_W wide, unsigned.
  - No multiply; GAP counts slots.
- tooth_idx and rev_start are registered, aligned to the vr_out rising edge (same cycle).

Optional Feature:
- TRIG_WHEEL_RAMP_EN defined:
  - At each slot end, L_per <= L_per + sign_extend(ramp_step), saturating to [4, 2^PERIOD_W-1].
  - Applies inside the revolution to emulate acceleration and deceleration.
  - The slot-0 latch from tooth_period still overrides L_per.
- TRIG_WHEEL_RAMP_EN undefined:
  - ramp_step is ignored.
  - L_per is constant within a revolution.

Test Plan:
- tooth_cnt=60, teeth_missing=2, tooth_period=100, enable=1 -> 58 rising edges spaced 100 clks, then one 300-clk spacing; vr_out high 50 clks per tooth; rev_start every 6000 clks.
- tooth_cnt=4, teeth_missing=0, tooth_period=5 -> high 2 clks, low 3 clks, no gap; tooth_idx sequence 0,1,2,3,0.
- Mid-rev change tooth_period 100->200 at idx 10 -> slots stay 100 until the next rev_start, then 200.
- enable dropped at idx 20 of a 60-2 wheel -> stream continues to the end of the gap, vr_out stays 0 afterwards, running=0, no rev_start.
- teeth_missing=59 with tooth_cnt=60 -> stays IDLE, cfg_err=1, vr_out=0; reset_n pulse clears cfg_err.
- With TRIG_WHEEL_RAMP_EN, period=100, ramp_step=-1 -> tooth k spacing 100-k, clamped at 4; async reset mid-HI -> vr_out=0 immediately.
